// File: rtl/quick_spi_arbiter.sv
// quick_spi_arbiter: round-robin sequencer that shares one quick_spi master
// engine among NUM_REQUESTERS clients. One request is accepted per handshake,
// its payload is held on the engine ports for the whole transaction, and the
// read data is returned to the owning client. A watchdog parks the block in a
// sticky fault state if the engine never signals end of transaction.
module quick_spi_arbiter #(
  parameter int NUM_REQUESTERS      = 4,
  parameter int INCOMING_DATA_WIDTH = 8,
  parameter int OUTGOING_DATA_WIDTH = 16,
  parameter int NUMBER_OF_SLAVES    = 2,
  parameter int TIMEOUT_CYCLES      = 1024
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [NUM_REQUESTERS-1:0]                     req_valid,
  output logic [NUM_REQUESTERS-1:0]                     req_ready,
  input  logic [NUM_REQUESTERS-1:0]                     req_operation,
  input  logic [NUM_REQUESTERS*NUMBER_OF_SLAVES-1:0]    req_slave,
  input  logic [NUM_REQUESTERS*OUTGOING_DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQUESTERS-1:0]                     rsp_valid,
  output logic [INCOMING_DATA_WIDTH-1:0]                rsp_data,
  output logic                                          fault,
  output logic                                          spi_enable,
  output logic                                          spi_start_transaction,
  output logic [NUMBER_OF_SLAVES-1:0]                   spi_slave,
  output logic                                          spi_operation,
  output logic [OUTGOING_DATA_WIDTH-1:0]                spi_outgoing_data,
  input  logic                                          spi_end_of_transaction,
  input  logic [INCOMING_DATA_WIDTH-1:0]                spi_incoming_data
);

  localparam int PTR_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  // One spare bit so ptr + offset never wraps before the modulo correction.
  localparam int CAND_W = PTR_W + 1;
  // Wide enough to hold TIMEOUT_CYCLES-1 for any TIMEOUT_CYCLES >= 1.
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    FAULT  = 2'd3
  } state_t;

  state_t                         state_q, state_d;
  logic [PTR_W-1:0]               ptr_q, ptr_d;
  logic [PTR_W-1:0]               owner_q, owner_d;
  logic [WD_W-1:0]                wd_q, wd_d;
  logic [NUMBER_OF_SLAVES-1:0]    spi_slave_q, spi_slave_d;
  logic                           spi_op_q, spi_op_d;
  logic [OUTGOING_DATA_WIDTH-1:0] spi_data_q, spi_data_d;
  logic [INCOMING_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [NUM_REQUESTERS-1:0]      rsp_valid_q, rsp_valid_d;
  logic                           fault_q, fault_d;
  logic                           spi_enable_q, spi_enable_d;

  logic                           winner_found;
  logic [PTR_W-1:0]               winner_idx;
  logic [PTR_W-1:0]               ptr_next;
  logic [CAND_W-1:0]              cand_idx;
  logic                           grant_en;
  logic                           handshake;

  logic [NUMBER_OF_SLAVES-1:0]    slave_arr [NUM_REQUESTERS];
  logic [OUTGOING_DATA_WIDTH-1:0] data_arr  [NUM_REQUESTERS];

  // Requests are only granted while idle and healthy.
  assign grant_en  = (state_q == IDLE) && !fault_q;
  assign handshake = grant_en && winner_found;

  // Unpack per-client payload fields and drive the one-hot ready.
  for (genvar gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_client
    assign slave_arr[gi] = req_slave[gi*NUMBER_OF_SLAVES +: NUMBER_OF_SLAVES];
    assign data_arr[gi]  = req_data[gi*OUTGOING_DATA_WIDTH +: OUTGOING_DATA_WIDTH];
    assign req_ready[gi] = handshake && (winner_idx == PTR_W'(gi));
  end

  // Round-robin search: first valid client starting at ptr, wrapping mod N.
  always_comb begin
    winner_found = 1'b0;
    winner_idx   = ptr_q;
    cand_idx     = '0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      cand_idx = {1'b0, ptr_q} + CAND_W'(k);
      if (cand_idx >= CAND_W'(NUM_REQUESTERS)) begin
        cand_idx = cand_idx - CAND_W'(NUM_REQUESTERS);
      end
      if (!winner_found && req_valid[cand_idx[PTR_W-1:0]]) begin
        winner_found = 1'b1;
        winner_idx   = cand_idx[PTR_W-1:0];
      end
    end
    if (winner_idx == PTR_W'(NUM_REQUESTERS - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = winner_idx + PTR_W'(1);
    end
  end

  // Next-state and datapath: accept, launch, wait for EOT or watchdog expiry.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    wd_d        = wd_q;
    spi_slave_d = spi_slave_q;
    spi_op_d    = spi_op_q;
    spi_data_d  = spi_data_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = '0;
    fault_d     = fault_q;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          spi_slave_d = slave_arr[winner_idx];
          spi_op_d    = req_operation[winner_idx];
          spi_data_d  = data_arr[winner_idx];
          owner_d     = winner_idx;
          ptr_d       = ptr_next;
          state_d     = LAUNCH;
        end
      end
      LAUNCH: begin
        wd_d    = '0;
        state_d = BUSY;
      end
      BUSY: begin
        // A completion on the very last allowed cycle still counts as success.
        if (spi_end_of_transaction) begin
          rsp_data_d           = spi_incoming_data;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = IDLE;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          fault_d = 1'b1;
          state_d = FAULT;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    spi_enable_d = (state_d != FAULT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      wd_q         <= '0;
      spi_slave_q  <= '0;
      spi_op_q     <= 1'b0;
      spi_data_q   <= '0;
      rsp_data_q   <= '0;
      rsp_valid_q  <= '0;
      fault_q      <= 1'b0;
      spi_enable_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      wd_q         <= wd_d;
      spi_slave_q  <= spi_slave_d;
      spi_op_q     <= spi_op_d;
      spi_data_q   <= spi_data_d;
      rsp_data_q   <= rsp_data_d;
      rsp_valid_q  <= rsp_valid_d;
      fault_q      <= fault_d;
      spi_enable_q <= spi_enable_d;
    end
  end

  assign spi_start_transaction = (state_q == LAUNCH);
  assign spi_slave             = spi_slave_q;
  assign spi_operation         = spi_op_q;
  assign spi_outgoing_data     = spi_data_q;
  assign rsp_valid             = rsp_valid_q;
  assign rsp_data              = rsp_data_q;
  assign fault                 = fault_q;
  assign spi_enable            = spi_enable_q;

endmodule

// File: tb/tb_quick_spi_arbiter.sv
// Self-checking bench for quick_spi_arbiter: a transaction-level model built
// from cycle timestamps predicts every output each cycle, and directed
// sections pin the model with hand-computed values.
module tb_quick_spi_arbiter;
  localparam int N  = 4;
  localparam int IW = 8;
  localparam int OW = 16;
  localparam int S  = 2;
  localparam int T  = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_operation;
  logic [N*S-1:0]  req_slave;
  logic [N*OW-1:0] req_data;
  logic [N-1:0]    rsp_valid;
  logic [IW-1:0]   rsp_data;
  logic            fault;
  logic            spi_enable;
  logic            spi_start_transaction;
  logic [S-1:0]    spi_slave;
  logic            spi_operation;
  logic [OW-1:0]   spi_outgoing_data;
  logic            spi_end_of_transaction;
  logic [IW-1:0]   spi_incoming_data;

  always #5 clk = ~clk;

  quick_spi_arbiter #(
    .NUM_REQUESTERS(N), .INCOMING_DATA_WIDTH(IW), .OUTGOING_DATA_WIDTH(OW),
    .NUMBER_OF_SLAVES(S), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_operation(req_operation),
    .req_slave(req_slave), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .fault(fault),
    .spi_enable(spi_enable), .spi_start_transaction(spi_start_transaction),
    .spi_slave(spi_slave), .spi_operation(spi_operation),
    .spi_outgoing_data(spi_outgoing_data),
    .spi_end_of_transaction(spi_end_of_transaction),
    .spi_incoming_data(spi_incoming_data)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit check_en = 1'b0;

  // Model: a transaction is described by its handshake cycle m_hs; start is
  // expected at m_hs+1, busy cycles run from m_hs+2 onward.
  bit            m_fault, m_in_txn, m_enable;
  int            m_ptr, m_owner, m_hs;
  logic          m_op;
  logic [S-1:0]  m_slave;
  logic [OW-1:0] m_data;
  logic [IW-1:0] m_rsp_data;
  logic [N-1:0]  m_rsp_vec;
  int            dut_grants[$];
  int            eot_at = -1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int rr_winner(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int w;
    logic [N-1:0] r;
    r = '0;
    if (!m_fault && !m_in_txn) begin
      w = rr_winner(req_valid, m_ptr);
      if (w >= 0) r[w] = 1'b1;
    end
    return r;
  endfunction

  // Apply the arbiter rules to the inputs present at the clock edge just taken.
  task automatic model_update();
    int w;
    m_rsp_vec = '0;
    if (reset) begin
      m_fault = 0; m_in_txn = 0; m_enable = 0; m_ptr = 0; m_owner = 0;
      m_op = 1'b0; m_slave = '0; m_data = '0; m_rsp_data = '0;
    end else begin
      if (!m_fault && !m_in_txn) begin
        w = rr_winner(req_valid, m_ptr);
        if (w >= 0) begin
          m_hs = cyc; m_in_txn = 1; m_owner = w;
          m_op = req_operation[w];
          m_slave = req_slave[w*S +: S];
          m_data = req_data[w*OW +: OW];
          m_ptr = (w + 1) % N;
        end
      end else if (m_in_txn && cyc >= m_hs + 2) begin
        if (spi_end_of_transaction) begin
          m_rsp_vec[m_owner] = 1'b1;
          m_rsp_data = spi_incoming_data;
          m_in_txn = 0;
        end else if (cyc - m_hs - 2 == T - 1) begin
          m_fault = 1;
          m_in_txn = 0;
        end
      end
      m_enable = !m_fault;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_update();
    cyc++;
    check_en = 1'b1;
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("req_ready", 32'(req_ready), 32'(exp_ready()));
      chk("spi_start", 32'(spi_start_transaction), 32'(m_in_txn && (cyc == m_hs + 1)));
      chk("spi_enable", 32'(spi_enable), 32'(m_enable));
      chk("fault", 32'(fault), 32'(m_fault));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_vec));
      chk("rsp_data", 32'(rsp_data), 32'(m_rsp_data));
      chk("spi_slave", 32'(spi_slave), 32'(m_slave));
      chk("spi_operation", 32'(spi_operation), 32'(m_op));
      chk("spi_outgoing_data", 32'(spi_outgoing_data), 32'(m_data));
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) dut_grants.push_back(i);
      end
    end
  end

  task automatic randomize_payload();
    req_operation = N'($urandom);
    req_slave     = (N*S)'($urandom);
    req_data      = {$urandom, $urandom};
  endtask

  // Free-running clients plus an engine stub that answers each start after
  // a random number of busy cycles (always inside the watchdog window).
  task automatic run(int n, bit rand_valid, int max_d, bit stray);
    for (int i = 0; i < n; i++) begin
      if (rand_valid) req_valid = N'($urandom);
      randomize_payload();
      if (m_in_txn && m_hs == cyc - 1) eot_at = cyc + 1 + int'($urandom_range(max_d, 0));
      spi_end_of_transaction = (m_in_txn && cyc == eot_at) ||
                               (stray && !m_in_txn && $urandom_range(7, 0) == 0);
      spi_incoming_data = IW'($urandom);
      tick();
    end
    spi_end_of_transaction = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    spi_end_of_transaction = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    req_valid = '0;
    spi_end_of_transaction = 1'b0;
    spi_incoming_data = '0;
    randomize_payload();

    // Reset values and enable rising one cycle after reset.
    do_reset();
    #2;
    chk("rst_enable", 32'(spi_enable), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_start", 32'(spi_start_transaction), 32'd0);
    tick();
    #2;
    chk("enable_after_rst", 32'(spi_enable), 32'd1);

    // Single read from client 2.
    req_valid = 4'b0100;
    req_operation[2] = 1'b0;
    req_slave[2*S +: S] = 2'd1;
    req_data[2*OW +: OW] = 16'hA5C3;
    tick();
    req_valid = '0;
    #2;
    chk("sr_start", 32'(spi_start_transaction), 32'd1);
    chk("sr_slave", 32'(spi_slave), 32'd1);
    chk("sr_data", 32'(spi_outgoing_data), 32'hA5C3);
    tick();
    #2;
    chk("sr_start_once", 32'(spi_start_transaction), 32'd0);
    spi_end_of_transaction = 1'b1;
    spi_incoming_data = 8'h5A;
    tick();
    spi_end_of_transaction = 1'b0;
    #2;
    chk("sr_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("sr_rsp_data", 32'(rsp_data), 32'h5A);
    tick();
    #2;
    chk("sr_rsp_pulse", 32'(rsp_valid), 32'd0);
    chk("sr_rsp_hold", 32'(rsp_data), 32'h5A);

    // Fairness with all clients requesting continuously.
    do_reset();
    dut_grants.delete();
    req_valid = 4'hF;
    run(40, 1'b0, 1, 1'b0);
    chk("fair_count_ge5", 32'(dut_grants.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (dut_grants.size() > i) chk("fair_order", 32'(dut_grants[i]), 32'(exp_order[i]));
    end
    req_valid = '0;
    run(20, 1'b0, 1, 1'b0);

    // Back-to-back: client 1 waiting while client 0 completes.
    do_reset();
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0010;
    tick();
    tick();
    spi_end_of_transaction = 1'b1;
    tick();
    spi_end_of_transaction = 1'b0;
    #2;
    chk("b2b_ready", 32'(req_ready), 32'h2);
    tick();
    #2;
    chk("b2b_start", 32'(spi_start_transaction), 32'd1);
    req_valid = '0;
    run(20, 1'b0, 2, 1'b0);

    // Watchdog: engine never answers.
    do_reset();
    req_valid = 4'b1000;
    tick();
    req_valid = 4'hF;
    for (int i = 0; i < 8; i++) tick();
    #2;
    chk("wd_not_yet", 32'(fault), 32'd0);
    tick();
    #2;
    chk("wd_fault", 32'(fault), 32'd1);
    chk("wd_enable", 32'(spi_enable), 32'd0);
    chk("wd_ready", 32'(req_ready), 32'd0);
    spi_end_of_transaction = 1'b1;
    tick();
    spi_end_of_transaction = 1'b0;
    tick();
    #2;
    chk("wd_sticky", 32'(fault), 32'd1);
    chk("wd_no_rsp", 32'(rsp_valid), 32'd0);
    do_reset();
    #2;
    chk("wd_cleared", 32'(fault), 32'd0);

    // EOT on the exact timeout cycle completes normally.
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    for (int i = 0; i < 8; i++) tick();
    spi_end_of_transaction = 1'b1;
    spi_incoming_data = 8'hC7;
    tick();
    spi_end_of_transaction = 1'b0;
    #2;
    chk("edge_fault", 32'(fault), 32'd0);
    chk("edge_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("edge_rsp_data", 32'(rsp_data), 32'hC7);

    // Stray EOT while idle.
    spi_end_of_transaction = 1'b1;
    tick();
    spi_end_of_transaction = 1'b0;
    #2;
    chk("stray_rsp", 32'(rsp_valid), 32'd0);

    // Reset in the middle of a transaction.
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #2;
    chk("rb_enable", 32'(spi_enable), 32'd0);
    chk("rb_start", 32'(spi_start_transaction), 32'd0);
    chk("rb_rsp_data", 32'(rsp_data), 32'd0);
    chk("rb_spi_data", 32'(spi_outgoing_data), 32'd0);
    req_valid = 4'hF;
    #1;
    chk("rb_ptr0_ready", 32'(req_ready), 32'h1);

    // Randomized traffic with dropped requests and stray EOTs.
    run(1500, 1'b1, 6, 1'b1);
    req_valid = '0;
    run(30, 1'b0, 6, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
